// File: rtl/pe_model.sv
// pe_model: compute-in-memory processing element built from a square grid of
// crossbar subarrays with fixed checkerboard binary weights, per-column
// saturating ADCs and an adder tree summing the SA rows of each SA column.
// Three pipeline stages: activation capture, ADC codes, adder-tree result.
module pe_model #(
  parameter int nSaRows          = 256,
  parameter int nSaCols          = nSaRows,
  parameter int nRowSaInPE       = 4,
  parameter int nColSaInPE       = nRowSaInPE,
  parameter int nStagesAdderTree = 4,
  parameter int saAdcBit         = 4,
  parameter int inputPrecision   = 4,
  parameter int adcShift         = 8,
  parameter int peSize           = nRowSaInPE * nSaRows,
  parameter int nAdderOutBits    = saAdcBit + nStagesAdderTree
) (
  input  logic                                                   clk,
  input  logic                                                   nrst,
  input  logic                                                   valid_i,
  input  logic [peSize-1:0][inputPrecision-1:0]                  pe_data_i,
  output logic [nSaCols-1:0][nColSaInPE-1:0][nAdderOutBits-1:0]  pe_data_o,
  output logic                                                   done_o
);

  // Full-width SA column sum: one activation width plus log2 of the rows summed.
  localparam int SumBits = inputPrecision + $clog2(nSaRows);
  localparam int AdcMax  = (1 << saAdcBit) - 1;

  // The weight w(gr,gc) is 1 exactly when gr and gc share parity, so every SA
  // column whose global column index has the same parity sees the same sum.
  // Only two distinct sums (and ADC codes) exist per SA row: index [sr][parity].
  logic [peSize-1:0][inputPrecision-1:0]                  act_q;
  logic                                                   v0_q;
  logic                                                   v1_q;
  logic [nRowSaInPE-1:0][1:0][SumBits-1:0]                par_sum;
  logic [nRowSaInPE-1:0][1:0][saAdcBit-1:0]               adc_d;
  logic [nRowSaInPE-1:0][1:0][saAdcBit-1:0]               adc_q;
  logic [nSaCols-1:0][nColSaInPE-1:0][nAdderOutBits-1:0]  tree_d;
  logic [SumBits-1:0]                                     shifted;
  logic [nAdderOutBits-1:0]                               acc;

  // Stage 0: capture the activation vector only when it is flagged valid.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      act_q <= '0;
      v0_q  <= 1'b0;
    end else begin
      v0_q <= valid_i;
      if (valid_i) act_q <= pe_data_i;
    end
  end

  // Crossbar dot products per SA row and weight parity, then the ADC:
  // truncating right shift followed by saturation at the maximum code.
  always_comb begin
    par_sum = '0;
    adc_d   = '0;
    shifted = '0;
    for (int sr = 0; sr < nRowSaInPE; sr++) begin
      for (int r = 0; r < nSaRows; r++) begin
        par_sum[sr][(sr * nSaRows + r) % 2] = par_sum[sr][(sr * nSaRows + r) % 2]
                                              + SumBits'(act_q[sr * nSaRows + r]);
      end
      for (int p = 0; p < 2; p++) begin
        shifted = par_sum[sr][p] >> adcShift;
        if (shifted > SumBits'(AdcMax)) adc_d[sr][p] = saAdcBit'(AdcMax);
        else                            adc_d[sr][p] = saAdcBit'(shifted);
      end
    end
  end

  // Stage 1: register the ADC codes of the vector captured in stage 0.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      adc_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) adc_q <= adc_d;
    end
  end

  // Adder tree: each output column sums the ADC codes of every SA row, picking
  // the code whose weight parity matches the global column index.
  always_comb begin
    tree_d = '0;
    acc    = '0;
    for (int k = 0; k < nColSaInPE; k++) begin
      for (int c = 0; c < nSaCols; c++) begin
        acc = '0;
        for (int sr = 0; sr < nRowSaInPE; sr++) begin
          acc = acc + nAdderOutBits'(adc_q[sr][(k * nSaCols + c) % 2]);
        end
        tree_d[c][k] = acc;
      end
    end
  end

  // Stage 2: publish the adder-tree result and pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pe_data_o <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= v1_q;
      if (v1_q) pe_data_o <= tree_d;
    end
  end

endmodule

// File: tb/tb_pe_model.sv
// tb_pe_model: scoreboard bench for pe_model. The stimulus process pushes the
// expected result and due cycle for each vector; a negedge monitor pops and
// compares whenever done_o is seen.
module tb_pe_model;

  localparam int NROWS = 256;
  localparam int NSR   = 4;
  localparam int NSC   = 4;
  localparam int PE    = NSR * NROWS;
  localparam int OBITS = 8;

  typedef logic [PE-1:0][3:0]                 vec_t;
  typedef logic [NROWS-1:0][NSC-1:0][OBITS-1:0] out_t;
  typedef struct {
    out_t data;
    int   due;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  logic valid_i;
  vec_t pe_data_i;
  out_t pe_data_o;
  logic done_o;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  pe_model dut (
    .clk       (clk),
    .nrst      (nrst),
    .valid_i   (valid_i),
    .pe_data_i (pe_data_i),
    .pe_data_o (pe_data_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  // Cycle counter advances on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Constant-filled expected output.
  function automatic out_t fill(input int val);
    out_t o;
    for (int c = 0; c < NROWS; c++)
      for (int k = 0; k < NSC; k++) o[c][k] = OBITS'(val);
    return o;
  endfunction

  // Reference: direct evaluation of the weight, dot product, ADC and sum.
  function automatic out_t ref_model(input vec_t v);
    out_t o;
    int gc, s, a, tot;
    for (int k = 0; k < NSC; k++) begin
      for (int c = 0; c < NROWS; c++) begin
        gc  = k * NROWS + c;
        tot = 0;
        for (int sr = 0; sr < NSR; sr++) begin
          s = 0;
          for (int r = 0; r < NROWS; r++)
            if (((sr * NROWS + r + gc) % 2) == 0) s += int'(v[sr * NROWS + r]);
          a = s >> 8;
          if (a > 15) a = 15;
          tot += a;
        end
        o[c][k] = OBITS'(tot);
      end
    end
    return o;
  endfunction

  // Compare the presented result and its arrival cycle against the scoreboard.
  task automatic check_output(input exp_t e);
    int fc, fk;
    checks++;
    if (pe_data_o !== e.data) begin
      failures++;
      fc = 0; fk = 0;
      for (int c = NROWS - 1; c >= 0; c--)
        for (int k = NSC - 1; k >= 0; k--)
          if (pe_data_o[c][k] !== e.data[c][k]) begin fc = c; fk = k; end
      $display("[TB] FAIL %s data: at [c=%0d][k=%0d] got %0d expected %0d",
               e.name, fc, fk, pe_data_o[fc][fk], e.data[fc][fk]);
    end
    checks++;
    if (cyc != e.due) begin
      failures++;
      $display("[TB] FAIL %s latency: done at cycle %0d expected cycle %0d", e.name, cyc, e.due);
    end
  endtask

  // Monitor: pops on done_o, flags unexpected and overdue results.
  always @(negedge clk) begin
    if (sb.size() > 0 && !done_o && cyc > sb[0].due) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s missing_done: none by cycle %0d expected %0d", sb[0].name, cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: done_o=1 at cycle %0d expected 0", cyc);
      end else begin
        check_output(sb.pop_front());
      end
    end
  end

  // Called at a negedge: present one valid vector and optionally expect it.
  task automatic apply_stimulus(input vec_t v, input out_t e, input bit expect_it, input string name);
    valid_i   = 1'b1;
    pe_data_i = v;
    if (expect_it) sb.push_back('{data: e, due: cyc + 3, name: name});
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Idle cycles with garbage on the data bus, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      for (int i = 0; i < PE; i++) pe_data_i[i] = 4'($urandom);
      @(negedge clk);
    end
  endtask

  // Direct check that outputs are cleared.
  task automatic check_zero(input string name);
    checks++;
    if (pe_data_o !== '0 || done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s: done_o=%b pe_data_o[0][0]=%0d expected done_o=0 and all outputs 0",
               name, done_o, pe_data_o[0][0]);
    end
  endtask

  vec_t v_max, v_par, v_floor, v_row0, v_row01, v_rand;
  out_t e_par;
  int   ub;

  initial begin
    nrst      = 1'b0;
    valid_i   = 1'b0;
    pe_data_i = '0;
    for (int i = 0; i < PE; i++) begin
      v_max[i]   = 4'd15;
      v_par[i]   = (i % 2 == 0) ? 4'd15 : 4'd0;
      v_floor[i] = (i == 0) ? 4'd15 : 4'd0;
      v_row0[i]  = (i < NROWS) ? 4'd15 : 4'd0;
      v_row01[i] = (i < 2 * NROWS) ? 4'd15 : 4'd0;
    end
    for (int c = 0; c < NROWS; c++)
      for (int k = 0; k < NSC; k++) e_par[c][k] = (c % 2 == 0) ? 8'd28 : 8'd0;

    // Reset held with valid toggling and full-scale data.
    pe_data_i = v_max;
    for (int i = 0; i < 5; i++) begin
      valid_i = i[0];
      @(negedge clk);
      check_zero("reset_hold");
    end

    // Release and accept on the first edge with nrst high.
    nrst = 1'b1;
    apply_stimulus(v_max, fill(28), 1'b1, "all_max");
    idle(5);
    apply_stimulus(v_par, e_par, 1'b1, "column_parity");
    idle(5);
    apply_stimulus(v_floor, fill(0), 1'b1, "quant_floor");
    idle(5);
    apply_stimulus(v_row0, fill(7), 1'b1, "sa_row0");
    idle(5);
    apply_stimulus(v_row01, fill(14), 1'b1, "sa_rows01");
    idle(5);

    // Back-to-back stream.
    apply_stimulus(v_par, e_par, 1'b1, "b2b_0");
    apply_stimulus(v_row0, fill(7), 1'b1, "b2b_1");
    apply_stimulus(v_row01, fill(14), 1'b1, "b2b_2");
    idle(6);

    // Reset one cycle after valid: vector discarded, outputs cleared.
    apply_stimulus(v_max, fill(28), 1'b0, "midreset");
    nrst = 1'b0;
    @(negedge clk);
    check_zero("midreset_0");
    @(negedge clk);
    check_zero("midreset_1");
    nrst = 1'b1;
    apply_stimulus(v_row0, fill(7), 1'b1, "after_reset");
    idle(5);

    // Random stream at 4-cycle spacing.
    for (int n = 0; n < 50; n++) begin
      ub = $urandom_range(0, 15);
      for (int i = 0; i < PE; i++) v_rand[i] = 4'($urandom_range(0, ub));
      apply_stimulus(v_rand, ref_model(v_rand), 1'b1, $sformatf("rand_%0d", n));
      idle(3);
    end

    // Drain, bounded.
    idle(10);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d results outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
